// File: rtl/mips_mem_pkg.sv
// Shared types and store/byte-enable helpers for the MIPS memory-access stage.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // The reserved size code 2'b11 behaves as a word access.
    function automatic size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] data);
        case (sz)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a read word and sign- or zero-extends it.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        load_unsigned,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: value = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: value = {{16{~load_unsigned & half_lane[15]}}, half_lane};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data bus, aligns load data and feeds MEM/WB.
//   state | meaning
//   IDLE  | accept EX/MEM instruction; ALU ops and misaligned ops retire in 1 cycle
//   WAIT  | bus request outstanding, upstream stalled until mem_ack or timeout
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_store_data,
    input  logic [4:0]        in_dest,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              out_valid,
    output logic [31:0]       out_complet,
    output logic [4:0]        out_dest,
    output logic              out_reg_write,
    output logic              misalign_exc,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state, state_nxt;
    size_t            in_sz;
    logic             mem_op, misaligned, start_access, timed_out;
    logic [CNT_W-1:0] cnt;

    // Instruction held across the bus access.
    logic [31:0] hold_alu;
    logic [4:0]  hold_dest;
    logic        hold_reg_write, hold_load, hold_unsigned;
    logic [1:0]  hold_addr_lo;
    size_t       hold_size;
    logic [31:0] load_value;

    assign in_sz        = decode_size(in_size);
    assign mem_op       = in_valid & (in_mem_read | in_mem_write);
    assign misaligned   = is_misaligned(in_sz, in_alu_result[1:0]);
    assign start_access = mem_op & ~misaligned;
    assign timed_out    = (cnt == CNT_LAST);

    load_align u_load_align (
        .rdata         (mem_rdata),
        .addr_lo       (hold_addr_lo),
        .size          (hold_size),
        .load_unsigned (hold_unsigned),
        .value         (load_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_access) state_nxt = WAIT;
            WAIT:    if (mem_ack || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall is forced low while reset is asserted so upstream never sees it mid-reset.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = start_access;
            WAIT:    stall = ~mem_ack;
            default: stall = 1'b0;
        endcase
        if (!rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= 4'b0000;
            mem_wdata      <= '0;
            cnt            <= '0;
            out_valid      <= 1'b0;
            out_complet    <= '0;
            out_dest       <= '0;
            out_reg_write  <= 1'b0;
            misalign_exc   <= 1'b0;
            bus_err        <= 1'b0;
            hold_alu       <= '0;
            hold_dest      <= '0;
            hold_reg_write <= 1'b0;
            hold_load      <= 1'b0;
            hold_unsigned  <= 1'b0;
            hold_addr_lo   <= 2'b00;
            hold_size      <= SZ_BYTE;
        end else begin
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    out_complet <= in_alu_result;
                    out_dest    <= in_dest;
                    if (start_access) begin
                        mem_req        <= 1'b1;
                        mem_we         <= in_mem_write;
                        mem_addr       <= {in_alu_result[ADDR_W-1:2], 2'b00};
                        mem_be         <= byte_en(in_sz, in_alu_result[1:0]);
                        mem_wdata      <= store_lanes(in_sz, in_store_data);
                        cnt            <= '0;
                        out_valid      <= 1'b0;
                        out_reg_write  <= 1'b0;
                        hold_alu       <= in_alu_result;
                        hold_dest      <= in_dest;
                        hold_reg_write <= in_reg_write;
                        hold_load      <= in_mem_read;
                        hold_unsigned  <= in_unsigned;
                        hold_addr_lo   <= in_alu_result[1:0];
                        hold_size      <= in_sz;
                    end else if (mem_op) begin
                        out_valid     <= 1'b1;
                        out_reg_write <= 1'b0;
                        misalign_exc  <= 1'b1;
                    end else begin
                        out_valid     <= in_valid;
                        out_reg_write <= in_valid & in_reg_write;
                    end
                end
                WAIT: begin
                    out_valid <= 1'b0;
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        out_valid     <= 1'b1;
                        out_dest      <= hold_dest;
                        out_complet   <= hold_load ? load_value : hold_alu;
                        out_reg_write <= hold_load & hold_reg_write;
                    end else if (timed_out) begin
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        bus_err       <= 1'b1;
                        out_valid     <= 1'b1;
                        out_dest      <= hold_dest;
                        out_complet   <= hold_alu;
                        out_reg_write <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage against an arithmetic reference model.
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_complet;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic        misalign_exc;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_dest       (in_dest),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_complet   (out_complet),
        .out_dest      (out_dest),
        .out_reg_write (out_reg_write),
        .misalign_exc  (misalign_exc),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model in plain arithmetic.
    function automatic logic m_mis(input logic [1:0] sz, input int a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input int a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input int a,
                                           input logic uns, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * a);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scramble();
        in_valid      = 1'b1;
        in_alu_result = $urandom;
        in_store_data = $urandom;
        in_dest       = 5'($urandom);
        in_reg_write  = 1'($urandom);
        in_mem_read   = 1'($urandom);
        in_mem_write  = ~in_mem_read;
        in_size       = 2'($urandom);
    endtask

    // Starts and ends at a falling edge; delay >= TO means the access never gets an ack.
    task automatic run_instr(input logic v, input logic [31:0] alu, input logic [31:0] data,
                             input logic [4:0] dest, input logic rw, input logic rd,
                             input logic wr, input logic [1:0] sz, input logic uns,
                             input int delay, input logic [31:0] rdata);
        logic memop, mis;
        int   a;
        a     = int'(alu[1:0]);
        memop = v & (rd | wr);
        mis   = m_mis(sz, a);
        in_valid = v; in_alu_result = alu; in_store_data = data; in_dest = dest;
        in_reg_write = rw; in_mem_read = rd; in_mem_write = wr; in_size = sz;
        in_unsigned = uns; mem_ack = 1'b0;
        #1;
        if (!memop || mis) begin
            chk1("stall_idle", stall, 1'b0);
            tick();
            in_valid = 1'b0;
            chk1("ov_1cyc", out_valid, memop ? 1'b1 : v);
            chk("oc_1cyc", out_complet, alu);
            chk("od_1cyc", 32'(out_dest), 32'(dest));
            chk1("orw_1cyc", out_reg_write, memop ? 1'b0 : (v & rw));
            chk1("misalign", misalign_exc, memop);
            chk1("req_1cyc", mem_req, 1'b0);
            chk1("buserr_1cyc", bus_err, 1'b0);
        end else begin
            chk1("stall_start", stall, 1'b1);
            tick();
            scramble();
            #1;
            chk1("req_start", mem_req, 1'b1);
            chk1("we", mem_we, wr);
            chk("addr", mem_addr, alu & 32'hFFFF_FFFC);
            chk("be", 32'(mem_be), 32'(m_be(sz, a)));
            if (wr) chk("wdata", mem_wdata, m_wdata(sz, data));
            chk1("ov_wait0", out_valid, 1'b0);
            for (int i = 0; i < ((delay < TO) ? delay : TO); i++) begin
                chk1("stall_wait", stall, 1'b1);
                chk1("req_wait", mem_req, 1'b1);
                chk1("ov_wait", out_valid, 1'b0);
                tick();
                scramble();
                #1;
            end
            if (delay >= TO) begin
                chk1("buserr", bus_err, 1'b1);
                chk1("ov_to", out_valid, 1'b1);
                chk1("orw_to", out_reg_write, 1'b0);
                chk1("req_to", mem_req, 1'b0);
                chk1("mis_to", misalign_exc, 1'b0);
                chk("od_to", 32'(out_dest), 32'(dest));
            end else begin
                in_valid  = 1'b0;
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                #1;
                chk1("stall_ack", stall, 1'b0);
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                @(negedge clk);
                chk1("ov_ack", out_valid, 1'b1);
                chk("oc_ack", out_complet, rd ? m_load(sz, a, uns, rdata) : alu);
                chk("od_ack", 32'(out_dest), 32'(dest));
                chk1("orw_ack", out_reg_write, rd ? rw : 1'b0);
                chk1("req_ack", mem_req, 1'b0);
                chk1("buserr_ack", bus_err, 1'b0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] alu;
        logic [1:0]  sz;
        int          op;
        int          dly;

        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        in_valid = 1'b1; in_alu_result = 32'h400; in_store_data = '0; in_dest = 5'd1;
        in_reg_write = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_size = 2'b10;
        in_unsigned = 1'b0;
        #12;
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_ov", out_valid, 1'b0);
        chk("rst_oc", out_complet, 32'h0);
        chk1("rst_orw", out_reg_write, 1'b0);
        chk1("rst_mis", misalign_exc, 1'b0);
        chk1("rst_berr", bus_err, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU pass-through
        run_instr(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        // lb / lbu from the top byte lane
        run_instr(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3, 32'h80FF_0000);
        chk("lb_value", out_complet, 32'hFFFF_FF80);
        run_instr(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3, 32'h80FF_0000);
        chk("lbu_value", out_complet, 32'h0000_0080);
        // sh to the upper half
        run_instr(1'b1, 32'h202, 32'hABCD_5678, 5'd9, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1, 32'h0);
        // misaligned lw
        run_instr(1'b1, 32'h301, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        // timeout followed by a back-to-back ALU op
        run_instr(1'b1, 32'h500, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, TO, 32'h0);
        run_instr(1'b1, 32'hCAFE_0001, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0);
        chk1("post_to_berr", bus_err, 1'b0);

        // reset in WAIT aborts the access; a late ack is ignored
        in_valid = 1'b1; in_alu_result = 32'h400; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_size = 2'b10;
        tick();
        tick();
        chk1("pre_rst_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("arst_req", mem_req, 1'b0);
        chk1("arst_stall", stall, 1'b0);
        chk1("arst_ov", out_valid, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk1("late_ack_ov", out_valid, 1'b0);
        chk1("late_ack_req", mem_req, 1'b0);

        // randomized mix
        for (int t = 0; t < 150; t++) begin
            op  = $urandom_range(0, 2);
            sz  = 2'($urandom);
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) alu[0] = 1'b0;
                if (sz >= 2'd2) alu[1:0] = 2'b00;
            end
            dly = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 5);
            run_instr($urandom_range(0, 9) != 0, alu, $urandom, 5'($urandom), 1'($urandom),
                      op == 1, op == 2, sz, 1'($urandom), dly, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
